spi_slave: RTL

//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), the target-side counterpart of spi (the master).

---
 rtl/spi_slave_pkg.sv | 7 +
 rtl/spi_slave_sync_edge_detect.sv | 35 +++
 rtl/spi_slave.sv | 103 ++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared SPI constants and the responder FSM state type
package spi_slave_pkg;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hff;
  localparam int SPI_BIT_CNT_W = 3;
  typedef logic [SPI_BIT_CNT_W-1:0] bit_cnt_t;
  typedef enum logic {ST_IDLE, ST_SHIFT} spi_state_e;
endpackage

// File: rtl/spi_slave_sync_edge_detect.sv
// spi_slave_sync_edge_detect: multi-flop synchronizer with registered rise/fall pulses
module spi_slave_sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic raw_clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] && !prev_q;
    fall_d = !sync_q[SYNC_STAGES-1] && prev_q;
  end
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (MSB first) oversampled in raw_clk,
// with a byte/ready/clear handshake on the bus side.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       busy,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       status_clear
);
  spi_state_e state_q, state_d;
  bit_cnt_t bit_cnt_q, bit_cnt_d, bit_base;
  logic [7:0] tx_hold_q, tx_hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic tx_full_q, tx_full_d, rx_ready_q, rx_ready_d;
  logic rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic [SYNC_STAGES:0] mosi_q, mosi_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic shift_st, start, in_frame, rise, fall, reload, done, mosi_sync;

  spi_slave_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .raw_clk(raw_clk), .reset(reset), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_slave_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .raw_clk(raw_clk), .reset(reset), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi gets one extra flop so it lines up with the registered edge pulses
  always_comb begin
    shift_st = state_q == ST_SHIFT;
    start = !shift_st && cs_fall;
    in_frame = start || (shift_st && !cs_rise);
    rise = sclk_rise && in_frame;
    fall = sclk_fall && shift_st && !cs_rise;
    bit_base = start ? '0 : bit_cnt_q;
    reload = start || (fall && bit_cnt_q == '0);
    done = rise && bit_base == '1;
    mosi_d = {mosi_q[SYNC_STAGES-1:0], spi_mosi};
    mosi_sync = mosi_q[SYNC_STAGES];
    state_d = start ? ST_SHIFT : (shift_st && cs_rise) ? ST_IDLE : state_q;
    bit_cnt_d = bit_base + bit_cnt_t'(rise);
    tx_hold_d = tx_load ? tx_data : tx_hold_q;
    tx_full_d = tx_load || (tx_full_q && !reload);
    tx_sh_d = reload ? (tx_full_q ? tx_hold_q : IDLE_BYTE) : fall ? {tx_sh_q[6:0], 1'b0} : tx_sh_q;
    tx_underrun_d = (reload && !tx_full_q) || (tx_underrun_q && !status_clear);
    rx_sh_d = rise ? {rx_sh_q[6:0], mosi_sync} : rx_sh_q;
    rx_data_d = done ? {rx_sh_q[6:0], mosi_sync} : rx_data_q;
    rx_ready_d = done || (rx_ready_q && !rx_ready_clear);
    rx_overrun_d = (done && rx_ready_q && !rx_ready_clear) || (rx_overrun_q && !status_clear);
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_hold_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      tx_full_q <= 1'b0;
      rx_ready_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      mosi_q <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_hold_q <= tx_hold_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      tx_full_q <= tx_full_d;
      rx_ready_q <= rx_ready_d;
      rx_overrun_q <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      mosi_q <= mosi_d;
    end
  end

  assign busy = state_q == ST_SHIFT;
  assign spi_miso = busy && tx_sh_q[7];
  assign spi_miso_oe = busy;
  assign tx_full = tx_full_q;
  assign rx_data = rx_data_q;
  assign rx_ready = rx_ready_q;
  assign rx_overrun = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
endmodule
